// File: rtl/regfile_write_buffer.sv
// Writeback buffer in front of a register file: a circular FIFO that drains one entry per cycle
// to the RF write port. It also forwards the youngest pending value for two read addresses.
module regfile_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_addr,
  input  logic [63:0]   in_data,
  input  logic          flush,
  input  logic          rf_hold,
  output logic          write_enabled,
  output logic [4:0]    write_addr,
  output logic [63:0]   write_data,
  input  logic [4:0]    lookup_addr_1,
  input  logic [4:0]    lookup_addr_2,
  output logic          fwd_hit_1,
  output logic          fwd_hit_2,
  output logic [63:0]   fwd_data_1,
  output logic [63:0]   fwd_data_2,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [4:0]    addr_q [DEPTH];
  logic [63:0]   data_q [DEPTH];
  logic          push, pop;

  assign count         = count_q;
  assign in_ready      = (count_q < CW'(DEPTH)) && !flush;
  assign write_enabled = (count_q != '0) && !rf_hold && !flush;
  assign write_addr    = (count_q != '0) ? addr_q[head_q] : '0;
  assign write_data    = (count_q != '0) ? data_q[head_q] : '0;
  assign pop           = write_enabled;
  // x31 is hardwired zero: the handshake completes but nothing is stored.
  assign push          = in_valid && in_ready && (in_addr != 5'd31);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
        tail_q         <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (addr_q[idx] == lookup_addr_1 && lookup_addr_1 != 5'd31) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = data_q[idx];
        end
        if (addr_q[idx] == lookup_addr_2 && lookup_addr_2 != 5'd31) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Bench for regfile_write_buffer: directed scenarios plus a randomized run against a queue model.
module tb_regfile_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, flush, rf_hold, write_enabled;
  logic [4:0]    in_addr, write_addr, lookup_addr_1, lookup_addr_2;
  logic [63:0]   in_data, write_data, fwd_data_1, fwd_data_2;
  logic          fwd_hit_1, fwd_hit_2;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  regfile_write_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_data(in_data), .flush(flush), .rf_hold(rf_hold), .write_enabled(write_enabled),
    .write_addr(write_addr), .write_data(write_data), .lookup_addr_1(lookup_addr_1),
    .lookup_addr_2(lookup_addr_2), .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2), .count(count)
  );

  typedef struct packed {logic [4:0] a; logic [63:0] d;} ent_t;
  ent_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic        exp_ready, exp_we, exp_hit1, exp_hit2;
  logic [4:0]  exp_waddr;
  logic [63:0] exp_wdata, exp_fd1, exp_fd2;
  int          exp_count;

  // Expected outputs from the pending-write queue and the current inputs.
  task automatic model_eval();
    exp_count = q.size();
    exp_ready = (q.size() < DEPTH) && !flush;
    exp_we    = (q.size() > 0) && !rf_hold && !flush;
    exp_waddr = (q.size() > 0) ? q[0].a : 5'd0;
    exp_wdata = (q.size() > 0) ? q[0].d : 64'd0;
    exp_hit1 = 1'b0; exp_fd1 = '0; exp_hit2 = 1'b0; exp_fd2 = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!exp_hit1 && lookup_addr_1 != 5'd31 && q[i].a == lookup_addr_1) begin
        exp_hit1 = 1'b1; exp_fd1 = q[i].d;
      end
      if (!exp_hit2 && lookup_addr_2 != 5'd31 && q[i].a == lookup_addr_2) begin
        exp_hit2 = 1'b1; exp_fd2 = q[i].d;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d, input logic fl,
                       input logic hold, input logic [4:0] la1, input logic [4:0] la2);
    @(negedge clk);
    in_valid = v; in_addr = a; in_data = d; flush = fl; rf_hold = hold;
    lookup_addr_1 = la1; lookup_addr_2 = la2;
    #1;
    model_eval();
  endtask

  task automatic advance();
    bit   do_pop, do_push, do_fl;
    ent_t e;
    do_fl   = flush;
    do_pop  = exp_we;
    do_push = in_valid && exp_ready && (in_addr != 5'd31);
    e.a = in_addr; e.d = in_data;
    @(posedge clk);
    if (do_fl) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_addr = 5'd4; in_data = 64'h1234; flush = 1'b0;
    rf_hold = 1'b0; lookup_addr_1 = 5'd4; lookup_addr_2 = 5'd4;
    #2 reset = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_tests++; if (write_enabled !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", write_enabled); end
    n_tests++; if (write_addr !== 5'd0 || write_data !== 64'd0) begin
      n_fail++; $display("FAIL reset_wdata: got %0d/%h want 0/0", write_addr, write_data); end
    n_tests++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 64'd0 || fwd_hit_2 !== 1'b0 || fwd_data_2 !== 64'd0) begin
      n_fail++; $display("FAIL reset_fwd: got %b/%h %b/%h want 0", fwd_hit_1, fwd_data_1, fwd_hit_2, fwd_data_2); end
    repeat (2) @(posedge clk);
    in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    drive(1, 5'd3, 64'hAA, 0, 0, 0, 0);
    n_tests++; if (in_ready !== 1'b1 || write_enabled !== 1'b0) begin
      n_fail++; $display("FAIL basic_first: got ready=%b we=%b want 1/0", in_ready, write_enabled); end
    advance();
    drive(1, 5'd7, 64'hBB, 0, 0, 0, 0);
    n_tests++; if (write_enabled !== 1'b1 || write_addr !== 5'd3 || write_data !== 64'hAA || count !== 3'd1) begin
      n_fail++; $display("FAIL basic_w1: got we=%b %0d/%h cnt=%0d want 1 3/aa 1", write_enabled, write_addr, write_data, count); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (write_enabled !== 1'b1 || write_addr !== 5'd7 || write_data !== 64'hBB || count !== 3'd1) begin
      n_fail++; $display("FAIL basic_w2: got we=%b %0d/%h cnt=%0d want 1 7/bb 1", write_enabled, write_addr, write_data, count); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (count !== 3'd0 || write_enabled !== 1'b0 || write_addr !== 5'd0) begin
      n_fail++; $display("FAIL basic_empty: got cnt=%0d we=%b addr=%0d want 0 0 0", count, write_enabled, write_addr); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'(i + 1), 64'h100 + 64'(i), 0, 1, 0, 0);
      n_tests++; if (in_ready !== (i < 4)) begin
        n_fail++; $display("FAIL full_ready%0d: got %b want %b", i, in_ready, (i < 4)); end
      advance();
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL full_count: got cnt=%0d ready=%b want 4/0", count, in_ready); end
    advance();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      n_tests++; if (write_enabled !== 1'b1 || write_addr !== 5'(i + 1) || write_data !== 64'h100 + 64'(i)) begin
        n_fail++; $display("FAIL full_drain%0d: got we=%b %0d/%h want 1 %0d/%h", i, write_enabled, write_addr,
                           write_data, i + 1, 64'h100 + 64'(i)); end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_end: got %0d want 0", count); end
  endtask

  task automatic test_forward();
    drive(1, 5'd5, 64'h1, 0, 1, 5'd5, 5'd6); advance();
    drive(1, 5'd5, 64'h2, 0, 1, 5'd5, 5'd6);
    n_tests++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 64'h1) begin
      n_fail++; $display("FAIL fwd_cur_in: got %b/%h want 1/1", fwd_hit_1, fwd_data_1); end
    advance();
    drive(0, 0, 0, 0, 1, 5'd5, 5'd6);
    n_tests++; if (fwd_hit_1 !== 1'b1 || fwd_data_1 !== 64'h2 || fwd_hit_2 !== 1'b0) begin
      n_fail++; $display("FAIL fwd_young: got %b/%h hit2=%b want 1/2 0", fwd_hit_1, fwd_data_1, fwd_hit_2); end
    advance();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 5'd5, 5'd6);
      n_tests++; if (write_enabled !== 1'b1 || fwd_hit_1 !== 1'b1 || fwd_data_1 !== 64'h2) begin
        n_fail++; $display("FAIL fwd_drain%0d: got we=%b %b/%h want 1 1/2", i, write_enabled, fwd_hit_1, fwd_data_1); end
      advance();
    end
    drive(1, 5'd5, 64'h3, 0, 0, 5'd5, 5'd6);
    n_tests++; if (fwd_hit_1 !== 1'b0 || fwd_data_1 !== 64'd0) begin
      n_fail++; $display("FAIL fwd_after: got %b/%h want 0/0", fwd_hit_1, fwd_data_1); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0); advance();
  endtask

  task automatic test_x31();
    drive(1, 5'd31, 64'hFF, 0, 0, 5'd31, 5'd31);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL x31_ready: got %b want 1", in_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 5'd31, 5'd31);
    n_tests++; if (count !== 3'd0 || write_enabled !== 1'b0 || fwd_hit_1 !== 1'b0) begin
      n_fail++; $display("FAIL x31_nostore: got cnt=%0d we=%b hit=%b want 0 0 0", count, write_enabled, fwd_hit_1); end
    advance();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin drive(1, 5'(10 + i), 64'(i), 0, 1, 0, 0); advance(); end
    drive(1, 5'd9, 64'h55, 1, 0, 0, 0);
    n_tests++; if (write_enabled !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL flush_cycle: got we=%b ready=%b want 0/0", write_enabled, in_ready); end
    advance();
    drive(1, 5'd2, 64'h9, 0, 0, 0, 0);
    n_tests++; if (count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_after: got cnt=%0d ready=%b want 0/1", count, in_ready); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (write_enabled !== 1'b1 || write_addr !== 5'd2 || write_data !== 64'h9) begin
      n_fail++; $display("FAIL flush_write: got we=%b %0d/%h want 1 2/9", write_enabled, write_addr, write_data); end
    advance();
  endtask

  task automatic test_reset_mid();
    drive(1, 5'd8, 64'h81, 0, 1, 5'd8, 5'd9); advance();
    drive(1, 5'd9, 64'h92, 0, 1, 5'd8, 5'd9); advance();
    drive(0, 0, 0, 0, 0, 5'd8, 5'd9);
    n_tests++; if (write_enabled !== 1'b1 || count !== 3'd2) begin
      n_fail++; $display("FAIL rstmid_pre: got we=%b cnt=%0d want 1/2", write_enabled, count); end
    #1 reset = 1'b0;
    #1;
    q.delete();
    n_tests++; if (count !== 3'd0 || write_enabled !== 1'b0 || write_addr !== 5'd0 || write_data !== 64'd0
                   || fwd_hit_1 !== 1'b0 || fwd_hit_2 !== 1'b0 || fwd_data_2 !== 64'd0) begin
      n_fail++; $display("FAIL rstmid_now: got cnt=%0d we=%b %0d/%h hit=%b%b want all 0", count, write_enabled,
                         write_addr, write_data, fwd_hit_1, fwd_hit_2); end
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 5'd8, 5'd9);
      n_tests++; if (write_enabled !== 1'b0 || count !== 3'd0) begin
        n_fail++; $display("FAIL rstmid_post%0d: got we=%b cnt=%0d want 0/0", i, write_enabled, count); end
      advance();
    end
  endtask

  task automatic test_random();
    logic [4:0] a, l1, l2;
    for (int c = 0; c < 400; c++) begin
      a  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      l1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      l2 = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, a, {$urandom, $urandom}, $urandom_range(0, 24) == 0,
            $urandom_range(0, 2) == 0, l1, l2);
      n_tests++; if (count !== CW'(exp_count) || in_ready !== exp_ready || write_enabled !== exp_we) begin
        n_fail++; $display("FAIL rnd_ctrl@%0d: got cnt=%0d rdy=%b we=%b want %0d %b %b", c, count, in_ready,
                           write_enabled, exp_count, exp_ready, exp_we); end
      n_tests++; if (write_addr !== exp_waddr || write_data !== exp_wdata) begin
        n_fail++; $display("FAIL rnd_write@%0d: got %0d/%h want %0d/%h", c, write_addr, write_data, exp_waddr, exp_wdata); end
      n_tests++; if (fwd_hit_1 !== exp_hit1 || fwd_data_1 !== exp_fd1 || fwd_hit_2 !== exp_hit2 || fwd_data_2 !== exp_fd2) begin
        n_fail++; $display("FAIL rnd_fwd@%0d: got %b/%h %b/%h want %b/%h %b/%h", c, fwd_hit_1, fwd_data_1, fwd_hit_2,
                           fwd_data_2, exp_hit1, exp_fd1, exp_hit2, exp_fd2); end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_forward();
    test_x31();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
